// File: rtl/keypad_if.sv
// Keypad pin and key-event bundle between the scanner (master) and its consumer/keypad side (slave).
`timescale 1ns/1ps
interface keypad_if;
  logic [3:0] rows;
  logic [4:0] cols;
  logic       newkey;
  logic [4:0] keycode;

  modport master (input rows, output cols, output newkey, output keycode);
  modport slave  (output rows, input cols, input newkey, input keycode);
endinterface

// File: rtl/keypad_scanner.sv
// 4x5 matrix keypad scanner: column scan, row sync, frame debounce, one keycode event per press.
// Optional auto-repeat of held digit keys when KEYPAD_AUTOREPEAT_EN is defined.
`timescale 1ns/1ps
module keypad_scanner #(
  parameter int SCAN_DIV      = 5000,
  parameter int DB_FRAMES     = 4,
  parameter int REPEAT_FRAMES = 100
) (
  input  logic     clk,
  input  logic     rst_n,
  keypad_if.master kp
);
  // state     | meaning
  // IDLE      | no key accepted, waiting for a single-key frame
  // DEB_PRESS | candidate key seen, counting identical frames
  // HELD      | key accepted and event fired, waiting for release
  // DEB_REL   | no key seen, counting empty frames before re-arming
  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DB_FRAMES > 1) ? $clog2(DB_FRAMES + 1) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DB_FRAMES);

  if (DB_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_bad_param
    $error("keypad_scanner: DB_FRAMES and REPEAT_FRAMES must be >= 1");
  end

  logic [3:0]    rows_s1_q, rows_s1_d, rows_s2_q, rows_s2_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [2:0]    col_q, col_d;
  logic [1:0]    hits_q, hits_d;
  logic [4:0]    hit_code_q, hit_code_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0]    cand_q, cand_d;
  logic          newkey_q, newkey_d;
  logic [4:0]    keycode_q, keycode_d;
  logic          fire;

  logic          col_end, frame_end;
  logic [3:0]    low_rows;
  logic [2:0]    n_low, hit_sum;
  logic [1:0]    row_idx, frame_hits;
  logic [4:0]    col_code, frame_code;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] REP_DONE = RW'(REPEAT_FRAMES);
  logic [RW-1:0] rep_q, rep_d, rep_inc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows_s1_q  <= 4'hF;
      rows_s2_q  <= 4'hF;
      dwell_q    <= '0;
      col_q      <= 3'd0;
      hits_q     <= 2'd0;
      hit_code_q <= 5'h00;
      state_q    <= IDLE;
      cnt_q      <= '0;
      cand_q     <= 5'h00;
      newkey_q   <= 1'b0;
      keycode_q  <= 5'h00;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q      <= '0;
`endif
    end else begin
      rows_s1_q  <= rows_s1_d;
      rows_s2_q  <= rows_s2_d;
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      hits_q     <= hits_d;
      hit_code_q <= hit_code_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      newkey_q   <= newkey_d;
      keycode_q  <= keycode_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q      <= rep_d;
`endif
    end
  end

  always_comb begin
    rows_s1_d = kp.rows;
    rows_s2_d = rows_s1_q;
    col_end   = (dwell_q == DWELL_LAST);
    frame_end = col_end && (col_q == 3'd4);
    dwell_d   = col_end ? '0 : dwell_q + 1'b1;
    col_d     = col_end ? ((col_q == 3'd4) ? 3'd0 : col_q + 3'd1) : col_q;

    // Per-frame accumulation: hit count saturates at 2 (MULTI), code of the first hit is kept.
    low_rows = ~rows_s2_q;
    n_low    = 3'(low_rows[0]) + 3'(low_rows[1]) + 3'(low_rows[2]) + 3'(low_rows[3]);
    row_idx  = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (low_rows[r]) row_idx = 2'(r);
    end
    col_code   = (col_q == 3'd4) ? ({3'b000, row_idx} + 5'd1) : {1'b1, row_idx, col_q[1:0]};
    hit_sum    = {1'b0, hits_q} + n_low;
    frame_hits = (hit_sum > 3'd1) ? 2'd2 : hit_sum[1:0];
    frame_code = (hits_q == 2'd0) ? col_code : hit_code_q;
    hits_d     = col_end ? (frame_end ? 2'd0 : frame_hits) : hits_q;
    hit_code_d = col_end ? frame_code : hit_code_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    cnt_inc = cnt_q + 1'b1;
    fire    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d   = rep_q;
    rep_inc = rep_q + 1'b1;
`endif
    if (frame_end) begin
      unique case (state_q)
        IDLE: if (frame_hits == 2'd1) begin
          cand_d = frame_code;
          if (DB_FRAMES <= 1) begin
            state_d = HELD;
            cnt_d   = '0;
            fire    = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d   = '0;
`endif
          end else begin
            state_d = DEB_PRESS;
            cnt_d   = CW'(1);
          end
        end
        DEB_PRESS: if (frame_hits == 2'd1 && frame_code == cand_q) begin
          if (cnt_inc >= CNT_DONE) begin
            state_d = HELD;
            cnt_d   = '0;
            fire    = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d   = '0;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (frame_hits == 2'd1) begin
          cand_d = frame_code;
          cnt_d  = CW'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        HELD: if (frame_hits == 2'd0) begin
          state_d = (DB_FRAMES <= 1) ? IDLE : DEB_REL;
          cnt_d   = (DB_FRAMES <= 1) ? '0 : CW'(1);
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          if (cand_q[4]) begin
            if (rep_inc >= REP_DONE) begin
              rep_d = '0;
              fire  = 1'b1;
            end else begin
              rep_d = rep_inc;
            end
          end
`endif
        end
        DEB_REL: if (frame_hits == 2'd0) begin
          if (cnt_inc >= CNT_DONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          // Contact came back: resume holding without a new event (repeat count is kept).
          state_d = HELD;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    newkey_d   = fire;
    keycode_d  = fire ? cand_d : keycode_q;
    kp.cols    = ~(5'b00001 << col_q);
    kp.newkey  = newkey_q;
    kp.keycode = keycode_q;
  end
endmodule
